// File: rtl/fir_stream_if.sv
// rtl/fir_stream_if.sv - rx/tx word channel and FIR engine handshake bundle
interface fir_stream_if #(
    parameter int DATA_W = 16,
    parameter int CH_W   = 2
);
    logic [DATA_W-1:0] data_in;
    logic              data_in_valid;
    logic              tx_done;
    logic [DATA_W-1:0] data_out;
    logic              data_out_valid;
    logic [CH_W-1:0]   eng_ch;
    logic              eng_wind;
    logic              eng_load;
    logic              eng_in_valid;
    logic [DATA_W-1:0] eng_data;
    logic              eng_out_valid;
    logic [DATA_W-1:0] eng_out;
    logic              core_busy;
    logic              err;

    modport slave (
        input  data_in, data_in_valid, tx_done, eng_out_valid, eng_out,
        output data_out, data_out_valid, eng_ch, eng_wind, eng_load,
               eng_in_valid, eng_data, core_busy, err
    );

    modport master (
        output data_in, data_in_valid, tx_done, eng_out_valid, eng_out,
        input  data_out, data_out_valid, eng_ch, eng_wind, eng_load,
               eng_in_valid, eng_data, core_busy, err
    );
endinterface

// File: rtl/fir_stream_core.sv
// rtl/fir_stream_core.sv - command sequencer between rx/tx word channels and a multi-channel FIR engine
module fir_stream_core #(
    parameter int DATA_W  = 16,
    parameter int NUM_CH  = 4,
    parameter int TAPS    = 16,
    parameter int MAX_LEN = 256,
    parameter int TIMEOUT = 4096,
    parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic        clk,
    input  logic        rstb,
    fir_stream_if.slave bus
);
    localparam int CNT_MAX = (MAX_LEN > TAPS) ? MAX_LEN : TAPS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int LEN_W   = DATA_W - 8;
    localparam int WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] OP_RUN    = 3'd1;
    localparam logic [2:0] OP_WIND   = 3'd2;
    localparam logic [2:0] OP_LOAD   = 3'd3;
    localparam logic [2:0] OP_STATUS = 3'd4;

    typedef enum logic [2:0] {
        IDLE, RX_WIND, RX_LOAD, RX_SAMPLE, WAIT_ENG, TX_WORD, TX_STATUS
    } state_t;

    state_t state_q, state_d;

    logic              rx_prev_q, tx_prev_q;
    logic              rx_ev, tx_ev;
    logic [CNT_W-1:0]  cnt_q;
    logic [LEN_W-1:0]  len_m1_q;
    logic [WD_W-1:0]   wd_q;
    logic              err_q;
    logic [2:0]        last_op_q;
    logic [CH_W-1:0]   last_ch_q;
    logic [CH_W-1:0]   ch_q;
    logic [DATA_W-1:0] data_out_q, eng_data_q;
    logic              dov_q, wind_q, load_q, in_valid_q;

    logic [2:0]        cmd_op;
    logic [CH_W-1:0]   cmd_ch;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_known, ch_ok, len_ok, cmd_ok;
    logic              in_rx, wd_expired, taps_last, run_last;
    logic [DATA_W-1:0] status_word;

    logic do_wind, do_load, do_samp, do_result, do_status;
    logic cnt_inc, cnt_clr, set_err, clr_err, take_cmd;

    assign rx_ev = bus.data_in_valid & ~rx_prev_q;
    assign tx_ev = bus.tx_done & ~tx_prev_q;

    assign cmd_op    = bus.data_in[2:0];
    assign cmd_ch    = bus.data_in[3 +: CH_W];
    assign cmd_len   = bus.data_in[DATA_W-1:8];
    assign cmd_known = (cmd_op >= OP_RUN) && (cmd_op <= OP_STATUS);
    assign ch_ok     = int'(cmd_ch) < NUM_CH;
    assign len_ok    = (cmd_op != OP_RUN) || (int'(cmd_len) < MAX_LEN);
    assign cmd_ok    = cmd_known && ch_ok && len_ok;

    assign in_rx      = (state_q == RX_WIND) || (state_q == RX_LOAD) || (state_q == RX_SAMPLE);
    assign wd_expired = in_rx && !rx_ev && (wd_q == WD_W'(TIMEOUT - 1));
    assign taps_last  = (cnt_q == CNT_W'(TAPS - 1));
    assign run_last   = (cnt_q == CNT_W'(len_m1_q));

    // Status reply: {err, last op, last channel, zero pad} from the MSB down
    always_comb begin
        status_word                    = '0;
        status_word[DATA_W-1]          = err_q;
        status_word[DATA_W-2 -: 3]     = last_op_q;
        status_word[DATA_W-5 -: CH_W]  = last_ch_q;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        do_wind   = 1'b0;
        do_load   = 1'b0;
        do_samp   = 1'b0;
        do_result = 1'b0;
        do_status = 1'b0;
        cnt_inc   = 1'b0;
        cnt_clr   = 1'b0;
        set_err   = 1'b0;
        clr_err   = 1'b0;
        take_cmd  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_ev) begin
                    take_cmd = 1'b1;
                    if (!cmd_ok) begin
                        set_err = 1'b1;
                    end else begin
                        case (cmd_op)
                            OP_RUN:  state_d = RX_SAMPLE;
                            OP_WIND: state_d = RX_WIND;
                            OP_LOAD: state_d = RX_LOAD;
                            default: begin
                                state_d   = TX_STATUS;
                                do_status = 1'b1;
                            end
                        endcase
                    end
                end
            end
            RX_WIND, RX_LOAD: begin
                if (rx_ev) begin
                    do_wind = (state_q == RX_WIND);
                    do_load = (state_q == RX_LOAD);
                    if (taps_last) begin
                        cnt_clr = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end else if (wd_expired) begin
                    set_err = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end
            end
            RX_SAMPLE: begin
                if (rx_ev) begin
                    do_samp = 1'b1;
                    state_d = WAIT_ENG;
                end else if (wd_expired) begin
                    set_err = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_ENG: begin
                if (bus.eng_out_valid) begin
                    do_result = 1'b1;
                    state_d   = TX_WORD;
                end
            end
            TX_WORD: begin
                if (tx_ev) begin
                    if (run_last) begin
                        cnt_clr = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_inc = 1'b1;
                        state_d = RX_SAMPLE;
                    end
                end
            end
            TX_STATUS: begin
                if (tx_ev) begin
                    clr_err = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rx_prev_q  <= 1'b0;
            tx_prev_q  <= 1'b0;
            cnt_q      <= '0;
            len_m1_q   <= '0;
            wd_q       <= '0;
            err_q      <= 1'b0;
            last_op_q  <= '0;
            last_ch_q  <= '0;
            ch_q       <= '0;
            data_out_q <= '0;
            eng_data_q <= '0;
            dov_q      <= 1'b0;
            wind_q     <= 1'b0;
            load_q     <= 1'b0;
            in_valid_q <= 1'b0;
        end else begin
            rx_prev_q  <= bus.data_in_valid;
            tx_prev_q  <= bus.tx_done;
            wind_q     <= do_wind;
            load_q     <= do_load;
            in_valid_q <= do_samp;
            dov_q      <= do_result | do_status;

            if (do_wind || do_load || do_samp) eng_data_q <= bus.data_in;

            if (do_result)      data_out_q <= bus.eng_out;
            else if (do_status) data_out_q <= status_word;

            if (cnt_clr)      cnt_q <= '0;
            else if (cnt_inc) cnt_q <= cnt_q + 1'b1;

            // Watchdog only ticks while waiting on rx; any fresh word restarts it
            if (!in_rx || rx_ev) wd_q <= '0;
            else                 wd_q <= wd_q + 1'b1;

            if (set_err)      err_q <= 1'b1;
            else if (clr_err) err_q <= 1'b0;

            if (take_cmd && cmd_op != OP_STATUS) begin
                last_op_q <= cmd_op;
                last_ch_q <= cmd_ch;
            end
            if (take_cmd && cmd_ok && cmd_op != OP_STATUS) begin
                ch_q     <= cmd_ch;
                len_m1_q <= cmd_len;
            end
        end
    end

    assign bus.data_out       = data_out_q;
    assign bus.data_out_valid = dov_q;
    assign bus.eng_ch         = ch_q;
    assign bus.eng_wind       = wind_q;
    assign bus.eng_load       = load_q;
    assign bus.eng_in_valid   = in_valid_q;
    assign bus.eng_data       = eng_data_q;
    assign bus.core_busy      = (state_q != IDLE);
    assign bus.err            = err_q;
endmodule

// File: tb/tb_fir_stream_core.sv
// tb/tb_fir_stream_core.sv - directed and randomized bench for fir_stream_core
module tb_fir_stream_core;
    localparam int DATA_W  = 16;
    localparam int NUM_CH  = 3;
    localparam int TAPS    = 16;
    localparam int MAX_LEN = 200;
    localparam int TIMEOUT = 4096;
    localparam int CH_W    = 2;

    logic clk  = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    fir_stream_if #(.DATA_W(DATA_W), .CH_W(CH_W)) bus ();

    fir_stream_core #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .TAPS(TAPS),
        .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT), .CH_W(CH_W)
    ) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    int txn_seen = 0;

    logic [DATA_W-1:0] wind_q[$];
    logic [DATA_W-1:0] load_q[$];
    logic [DATA_W-1:0] samp_q[$];
    logic [DATA_W-1:0] tx_q[$];

    bit                eng_en = 1'b1;
    bit                eng_pend = 1'b0;
    int                eng_cd = 0;
    logic [DATA_W-1:0] eng_val = '0;

    bit m_err;
    int m_op;
    int m_ch;

    logic [63:0] out_vec;
    assign out_vec = {24'd0, bus.data_out, bus.data_out_valid, bus.eng_ch, bus.eng_wind,
                      bus.eng_load, bus.eng_in_valid, bus.eng_data, bus.core_busy, bus.err};

    always @(negedge clk) begin
        if (bus.eng_wind)       wind_q.push_back(bus.eng_data);
        if (bus.eng_load)       load_q.push_back(bus.eng_data);
        if (bus.eng_in_valid)   samp_q.push_back(bus.eng_data);
        if (bus.data_out_valid) tx_q.push_back(bus.data_out);
    end

    // Engine stand-in: returns x+1 a few cycles after each sample
    always @(negedge clk) begin
        bus.eng_out_valid = 1'b0;
        if (!rstb) begin
            eng_pend = 1'b0;
            bus.eng_out = '0;
        end else if (eng_en) begin
            if (eng_pend) begin
                if (eng_cd == 0) begin
                    bus.eng_out_valid = 1'b1;
                    bus.eng_out = eng_val + 16'd1;
                    eng_pend = 1'b0;
                end else begin
                    eng_cd--;
                end
            end
            if (bus.eng_in_valid) begin
                eng_pend = 1'b1;
                eng_cd   = 2;
                eng_val  = bus.eng_data;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w, input int hold);
        @(negedge clk);
        bus.data_in = w;
        bus.data_in_valid = 1'b1;
        repeat (hold - 1) @(negedge clk);
        @(negedge clk);
        bus.data_in_valid = 1'b0;
        bus.data_in = DATA_W'($urandom);
    endtask

    function automatic logic [DATA_W-1:0] status_exp(input bit e, input int op, input int ch);
        int v;
        v = (e ? 32'h8000 : 0) + (op << 12) + (ch << 10);
        return v[DATA_W-1:0];
    endfunction

    task automatic send_cmd(input logic [DATA_W-1:0] w);
        int op, ch, len;
        bit ok;
        op = int'(w[2:0]);
        ch = int'(w[4:3]);
        len = int'(w[15:8]);
        ok = (op >= 1) && (op <= 4) && (ch < NUM_CH) && !(op == 1 && len + 1 > MAX_LEN);
        if (op != 4) begin
            m_op = op;
            m_ch = ch;
        end
        if (!ok) m_err = 1'b1;
        send_word(w, $urandom_range(1, 3));
    endtask

    task automatic wait_tx(input string tag, input logic [DATA_W-1:0] exp);
        int t;
        t = 0;
        while (tx_q.size() <= txn_seen && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_count"}, 64'(tx_q.size()), 64'(txn_seen + 1));
        if (tx_q.size() > txn_seen) chk({tag, "_word"}, 64'(tx_q[txn_seen]), 64'(exp));
        tick($urandom_range(0, 3));
        chk({tag, "_stable"}, 64'(bus.data_out), 64'(exp));
        @(negedge clk);
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        txn_seen++;
    endtask

    task automatic do_status();
        logic [DATA_W-1:0] e;
        e = status_exp(m_err, m_op, m_ch);
        send_word(16'h0004, $urandom_range(1, 3));
        wait_tx("status", e);
        m_err = 1'b0;
        tick(2);
        chk("status_clears_err", 64'(bus.err), 64'(m_err));
        chk("status_idle", 64'(bus.core_busy), 64'd0);
    endtask

    task automatic run_cmd(input int n, input int ch, input int hold);
        logic [DATA_W-1:0] s[$];
        samp_q.delete();
        send_cmd(DATA_W'(((n - 1) << 8) | (ch << 3) | 1));
        for (int i = 0; i < n; i++) begin
            s.push_back(($urandom_range(0, 7) == 0) ? 16'hFFFF : DATA_W'($urandom));
            send_word(s[i], hold);
            wait_tx("run_tx", s[i] + 16'd1);
        end
        tick(2);
        chk("run_idle", 64'(bus.core_busy), 64'd0);
        chk("run_ch", 64'(bus.eng_ch), 64'(ch));
        chk("run_nsamp", 64'(samp_q.size()), 64'(n));
        for (int i = 0; i < n && i < samp_q.size(); i++)
            chk("run_eng_data", 64'(samp_q[i]), 64'(s[i]));
    endtask

    initial begin
        logic [DATA_W-1:0] lw[TAPS];
        logic [DATA_W-1:0] ds[3];
        int ch;
        int tx_before;

        bus.data_in = '0;
        bus.data_in_valid = 1'b0;
        bus.tx_done = 1'b0;
        m_err = 1'b0;
        m_op = 0;
        m_ch = 0;
        tick(3);
        chk("reset_outputs", out_vec, 64'd0);
        @(negedge clk);
        rstb = 1'b1;
        tick(2);
        chk("post_reset_outputs", out_vec, 64'd0);

        // WIND ch2 with words 1..16
        send_cmd(16'h0012);
        for (int i = 1; i <= TAPS; i++) begin
            send_word(DATA_W'(i), $urandom_range(1, 3));
            tick($urandom_range(0, 2));
        end
        tick(2);
        chk("wind_count", 64'(wind_q.size()), 64'(TAPS));
        for (int i = 0; i < TAPS && i < wind_q.size(); i++)
            chk("wind_data", 64'(wind_q[i]), 64'(i + 1));
        chk("wind_ch", 64'(bus.eng_ch), 64'd2);
        chk("wind_idle", 64'(bus.core_busy), 64'd0);
        chk("wind_no_load", 64'(load_q.size() + samp_q.size() + tx_q.size()), 64'd0);

        // LOAD on a random channel with random words
        ch = $urandom_range(0, NUM_CH - 1);
        send_cmd(DATA_W'((ch << 3) | 3));
        for (int i = 0; i < TAPS; i++) begin
            lw[i] = DATA_W'($urandom);
            send_word(lw[i], $urandom_range(1, 2));
        end
        tick(2);
        chk("load_count", 64'(load_q.size()), 64'(TAPS));
        for (int i = 0; i < TAPS && i < load_q.size(); i++)
            chk("load_data", 64'(load_q[i]), 64'(lw[i]));
        chk("load_ch", 64'(bus.eng_ch), 64'(ch));
        chk("load_idle", 64'(bus.core_busy), 64'd0);

        // RUN n=3 ch0 with samples 5,6,7
        samp_q.delete();
        ds[0] = 16'd5; ds[1] = 16'd6; ds[2] = 16'd7;
        send_cmd(16'h0201);
        for (int i = 0; i < 3; i++) begin
            send_word(ds[i], 1);
            wait_tx("run3_tx", ds[i] + 16'd1);
        end
        tick(2);
        chk("run3_idle", 64'(bus.core_busy), 64'd0);
        chk("run3_nsamp", 64'(samp_q.size()), 64'd3);

        for (int k = 0; k < 3; k++)
            run_cmd($urandom_range(1, 5), $urandom_range(0, NUM_CH - 1), $urandom_range(1, 3));

        // Bad opcode, then STATUS
        wind_q.delete(); load_q.delete(); samp_q.delete();
        send_cmd(16'h0007);
        tick(3);
        chk("badop_err", 64'(bus.err), 64'(m_err));
        chk("badop_idle", 64'(bus.core_busy), 64'd0);
        chk("badop_no_eng", 64'(wind_q.size() + load_q.size() + samp_q.size()), 64'd0);
        do_status();

        // Channel out of range
        send_cmd(16'h0019);
        tick(3);
        chk("badch_err", 64'(bus.err), 64'(m_err));
        chk("badch_idle", 64'(bus.core_busy), 64'd0);
        do_status();

        // Length one past MAX_LEN
        send_cmd(DATA_W'((MAX_LEN << 8) | 1));
        tick(3);
        chk("badlen_err", 64'(bus.err), 64'(m_err));
        chk("badlen_idle", 64'(bus.core_busy), 64'd0);
        do_status();
        do_status();

        // Watchdog: a gap just under TIMEOUT survives, a full TIMEOUT aborts
        samp_q.delete();
        send_cmd(16'h0201);
        send_word(16'h1234, 1);
        wait_tx("wd_tx0", 16'h1235);
        tick(TIMEOUT - 40);
        chk("wd_near_err", 64'(bus.err), 64'd0);
        send_word(16'h0042, 2);
        wait_tx("wd_tx1", 16'h0043);
        tick(TIMEOUT - 20);
        chk("wd_before_err", 64'(bus.err), 64'd0);
        chk("wd_before_busy", 64'(bus.core_busy), 64'd1);
        tick(40);
        m_err = 1'b1;
        chk("wd_err", 64'(bus.err), 64'(m_err));
        chk("wd_idle", 64'(bus.core_busy), 64'd0);
        chk("wd_nsamp", 64'(samp_q.size()), 64'd2);
        do_status();

        // Longest legal RUN accepted, then reset while waiting on the engine
        samp_q.delete();
        send_cmd(DATA_W'(((MAX_LEN - 1) << 8) | 1));
        tick(2);
        chk("maxlen_busy", 64'(bus.core_busy), 64'd1);
        chk("maxlen_err", 64'(bus.err), 64'd0);
        eng_en = 1'b0;
        send_word(16'h0AAA, 1);
        tick(5);
        chk("waiteng_sample", 64'(samp_q.size()), 64'd1);
        chk("waiteng_busy", 64'(bus.core_busy), 64'd1);
        tx_before = tx_q.size();
        @(negedge clk);
        rstb = 1'b0;
        #1;
        chk("async_reset_outputs", out_vec, 64'd0);
        tick(2);
        rstb = 1'b1;
        eng_en = 1'b1;
        m_err = 1'b0;
        m_op = 0;
        m_ch = 0;
        tick(4);
        chk("after_reset_outputs", out_vec, 64'd0);
        chk("after_reset_no_tx", 64'(tx_q.size()), 64'(tx_before));

        // Level-held data_in_valid: one word per rising edge
        run_cmd(1, 1, 10);
        do_status();

        tick(5);
        chk("tx_total", 64'(tx_q.size()), 64'(txn_seen));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
